// File: rtl/staging_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : staging_pipeline_if
// Purpose  : Streaming bundle for staging_pipeline. It groups the producer
//            side (in_*, half_sel), the consumer side (out_*), and the
//            counter control/status.
// Modports : master - the producer/consumer environment.
//            slave  - the staging_pipeline block.
// Revision : 1.0 - initial release
// ============================================================================
interface staging_pipeline_if #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
);
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   half_sel;
  logic [WIDTH-1:0]       out_data;
  logic                   out_above;
  logic                   out_valid;
  logic                   out_ready;
  logic                   count_clear;
  logic [COUNT_WIDTH-1:0] above_count;

  modport master (
    output in_data, in_valid, half_sel, out_ready, count_clear,
    input  in_ready, out_data, out_above, out_valid, above_count
  );

  modport slave (
    input  in_data, in_valid, half_sel, out_ready, count_clear,
    output in_ready, out_data, out_above, out_valid, above_count
  );
endinterface
`default_nettype wire

// File: rtl/staging_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : staging_pipeline
// Purpose  : Elastic DEPTH-stage pipeline. Each accepted word is compared
//            against THRESHOLD and reformatted as {HEADER, selected half or
//            zero}. The result is carried through DEPTH valid/ready register
//            stages. A saturating counter tracks delivered above-threshold
//            words.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous active-high reset
//            bus (slave)  - in_data/in_valid/in_ready/half_sel (producer),
//                           out_data/out_above/out_valid/out_ready (consumer),
//                           count_clear/above_count (event counter)
// Params   : WIDTH (even, >= 4), DEPTH (>= 1), THRESHOLD, HEADER, COUNT_WIDTH
// Revision : 1.0 - initial release
// ============================================================================
module staging_pipeline #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] THRESHOLD   = WIDTH'(100),
  parameter int unsigned      HEADER      = 1,
  parameter int               COUNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  staging_pipeline_if.slave  bus
);

  localparam int                     c_half      = WIDTH / 2;
  localparam logic [c_half-1:0]      c_header    = (c_half)'(HEADER);
  localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;

  logic [WIDTH-1:0]       r_data [DEPTH];
  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       r_above;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [DEPTH-1:0]       w_ready;
  logic                   w_chain;
  logic                   w_above;
  logic [c_half-1:0]      w_half;
  logic [WIDTH-1:0]       w_word;
  logic                   w_deliver_above;

  // Input transform. The lower half is zeroed for words at or below the
  // threshold, so half_sel only has an effect on above-threshold words.
  always_comb begin
    w_above = (bus.in_data > THRESHOLD);
    w_half  = bus.half_sel ? bus.in_data[c_half-1:0] : bus.in_data[WIDTH-1:c_half];
    w_word  = {c_header, (w_above ? w_half : {c_half{1'b0}})};
  end

  // Stage i can advance when it or any stage downstream of it is empty, or
  // when the consumer is taking the output. The chain is accumulated from
  // the output end, which gives a purely combinational out_ready-to-in_ready
  // path with no bubbles.
  always_comb begin
    w_ready = '0;
    w_chain = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_chain    = w_chain || !r_valid[i];
      w_ready[i] = w_chain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_above <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= bus.in_valid;
        r_data[0]  <= w_word;
        r_above[0] <= w_above;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_ready[i]) begin
          r_valid[i] <= r_valid[i-1];
          r_data[i]  <= r_data[i-1];
          r_above[i] <= r_above[i-1];
        end
      end
    end
  end

  assign w_deliver_above = r_valid[DEPTH-1] && bus.out_ready && r_above[DEPTH-1];

  // A clear wins over a simultaneous delivery, and that delivery is not
  // counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (bus.count_clear) begin
      r_count <= '0;
    end else if (w_deliver_above && (r_count != c_count_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.in_ready    = w_ready[0];
  assign bus.out_valid   = r_valid[DEPTH-1];
  assign bus.out_data    = r_data[DEPTH-1];
  assign bus.out_above   = r_above[DEPTH-1];
  assign bus.above_count = r_count;

endmodule
`default_nettype wire
